// File: rtl/arm7_mem_pkg.sv
// Shared types and helpers for the ARM7 load/store stage: FSM states,
// access-size encoding and the ARM7 unaligned-word rotation.
package arm7_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WR_ISSUE   = 2'd1,
        ST_RD_ISSUE   = 2'd2,
        ST_RD_CAPTURE = 2'd3
    } mau_state_e;

    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_BYTE = 1'b1;

    // Unaligned LDR returns the aligned word rotated right by 8*addr[1:0].
    function automatic logic [31:0] rotate_load(input logic [31:0] word,
                                                input logic [1:0]  addr_lo);
        logic [31:0] r;
        case (addr_lo)
            2'd0:    r = word;
            2'd1:    r = {word[7:0],  word[31:8]};
            2'd2:    r = {word[15:0], word[31:16]};
            default: r = {word[23:0], word[31:24]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Formats raw memory read data into the register-writeback value:
// rotated word for LDR, zero-extended byte for LDRB.
module load_formatter
    import arm7_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [7:0]  byte_i,
    input  logic        size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    always_comb begin
        if (size_i == SZ_BYTE) begin
            data_o = {24'h0, byte_i};
        end else begin
            data_o = rotate_load(word_i, addr_lo_i);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// ARM7 load/store stage: accepts one LDR/STR/LDRB/STRB at a time and drives
// the data_memory word/byte ports, returning formatted load data to writeback.
module mem_access_unit
    import arm7_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // A request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and request fields are sampled on that edge.
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_rd,
    output logic                  write_word_en,
    output logic                  write_byte_en,
    output logic                  read_word_en,
    output logic                  read_byte_en,
    output logic [31:0]           write_word_address,
    output logic [31:0]           write_byte_address,
    output logic [31:0]           read_word_address,
    output logic [31:0]           read_byte_address,
    output logic [31:0]           write_word_data,
    output logic [7:0]            write_byte_data,
    input  logic [31:0]           read_word_data,
    input  logic [7:0]            read_byte_data,
    output logic                  wb_valid,
    output logic [3:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    mau_state_e  state_q, state_d;
    logic        size_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  rd_q;
    logic [31:0] wwa_q, wba_q, rwa_q, rba_q, wwd_q;
    logic [7:0]  wbd_q;
    logic        wb_valid_q, wb_valid_d;
    logic        done_q, done_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        accept;
    logic [31:0] addr32, addr_word;
    logic [31:0] fmt_data;

    assign addr32    = 32'(req_addr);
    assign addr_word = {addr32[31:2], 2'b00};
    assign accept    = (state_q == ST_IDLE) && req_valid;

    load_formatter u_fmt (
        .word_i    (read_word_data),
        .byte_i    (read_byte_data),
        .size_i    (size_q),
        .addr_lo_i (addr_lo_q),
        .data_o    (fmt_data)
    );

    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        done_d     = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = req_load ? ST_RD_ISSUE : ST_WR_ISSUE;
            end
            ST_WR_ISSUE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                state_d    = ST_IDLE;
                wb_valid_d = 1'b1;
                done_d     = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = fmt_data;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side address/data are loaded on accept so they are stable for
    // the whole issue cycle, and otherwise hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            size_q     <= SZ_WORD;
            addr_lo_q  <= 2'd0;
            rd_q       <= 4'd0;
            wwa_q      <= 32'd0;
            wba_q      <= 32'd0;
            rwa_q      <= 32'd0;
            rba_q      <= 32'd0;
            wwd_q      <= 32'd0;
            wbd_q      <= 8'd0;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            wb_rd_q    <= 4'd0;
            wb_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            done_q     <= done_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            if (accept) begin
                size_q    <= req_byte;
                addr_lo_q <= addr32[1:0];
                rd_q      <= req_rd;
                if (!req_load && !req_byte) begin
                    wwa_q <= addr_word;
                    wwd_q <= req_wdata;
                end
                if (!req_load && req_byte) begin
                    wba_q <= addr32;
                    wbd_q <= req_wdata[7:0];
                end
                if (req_load && !req_byte) rwa_q <= addr_word;
                if (req_load && req_byte)  rba_q <= addr32;
            end
        end
    end

    assign req_ready          = (state_q == ST_IDLE);
    assign write_word_en      = (state_q == ST_WR_ISSUE) && (size_q == SZ_WORD);
    assign write_byte_en      = (state_q == ST_WR_ISSUE) && (size_q == SZ_BYTE);
    assign read_word_en       = (state_q == ST_RD_ISSUE) && (size_q == SZ_WORD);
    assign read_byte_en       = (state_q == ST_RD_ISSUE) && (size_q == SZ_BYTE);
    assign write_word_address = wwa_q;
    assign write_byte_address = wba_q;
    assign read_word_address  = rwa_q;
    assign read_byte_address  = rba_q;
    assign write_word_data    = wwd_q;
    assign write_byte_data    = wbd_q;
    assign wb_valid           = wb_valid_q;
    assign done               = done_q;
    assign wb_rd              = wb_rd_q;
    assign wb_data            = wb_data_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural data_memory, byte-array reference
// model, expectation queues drained by a negedge monitor.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_load, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_rd;
    logic        write_word_en, write_byte_en, read_word_en, read_byte_en;
    logic [31:0] write_word_address, write_byte_address, read_word_address, read_byte_address;
    logic [31:0] write_word_data;
    logic [7:0]  write_byte_data;
    logic [31:0] read_word_data;
    logic [7:0]  read_byte_data;
    logic        wb_valid, done;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  dbg_state;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .write_word_en(write_word_en), .write_byte_en(write_byte_en),
        .read_word_en(read_word_en), .read_byte_en(read_byte_en),
        .write_word_address(write_word_address), .write_byte_address(write_byte_address),
        .read_word_address(read_word_address), .read_byte_address(read_byte_address),
        .write_word_data(write_word_data), .write_byte_data(write_byte_data),
        .read_word_data(read_word_data), .read_byte_data(read_byte_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- data_memory model ----------------
    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (write_word_en) begin
            mem[16'(write_word_address)]         <= write_word_data[7:0];
            mem[16'(write_word_address + 32'd1)] <= write_word_data[15:8];
            mem[16'(write_word_address + 32'd2)] <= write_word_data[23:16];
            mem[16'(write_word_address + 32'd3)] <= write_word_data[31:24];
        end
        if (write_byte_en) mem[16'(write_byte_address)] <= write_byte_data;
        if (read_word_en)
            read_word_data <= {mem[16'(read_word_address + 32'd3)], mem[16'(read_word_address + 32'd2)],
                               mem[16'(read_word_address + 32'd1)], mem[16'(read_word_address)]};
        if (read_byte_en) read_byte_data <= mem[16'(read_byte_address)];
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0] ref_mem [0:65535];

    typedef struct {
        int          cyc;
        int          kind;   // 0 word write, 1 byte write, 2 word read, 3 byte read
        logic [31:0] addr;
        logic [31:0] data;
    } memop_t;

    memop_t      op_q[$];
    logic [67:0] exp_q[$];   // {accept cycle, rd, data}
    int          done_q[$];  // cycle in which done must be seen

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] ref_load(input logic byt, input logic [31:0] addr);
        logic [31:0] base, word;
        logic [63:0] dbl;
        if (byt) return {24'h0, ref_mem[16'(addr)]};
        base = addr & ~32'h3;
        word = {ref_mem[16'(base + 32'd3)], ref_mem[16'(base + 32'd2)],
                ref_mem[16'(base + 32'd1)], ref_mem[16'(base)]};
        dbl  = {word, word} >> (8 * addr[1:0]);
        return dbl[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic ld, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] rd, input bit hold,
                         output int acc);
        int     waited;
        memop_t op;
        waited = 0;
        acc    = -1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            flag("req_ready wait", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        req_load  = ld;
        req_byte  = byt;
        req_addr  = addr;
        req_wdata = wd;
        req_rd    = rd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc     = cyc;
        op.cyc  = acc;
        op.kind = (ld ? 2 : 0) + (byt ? 1 : 0);
        op.addr = byt ? addr : (addr & ~32'h3);
        op.data = ld ? 32'd0 : (byt ? {24'h0, wd[7:0]} : wd);
        op_q.push_back(op);
        if (ld) begin
            exp_q.push_back({32'(acc + 2), rd, ref_load(byt, addr)});
            done_q.push_back(acc + 2);
        end else begin
            if (byt) begin
                ref_mem[16'(addr)] = wd[7:0];
            end else begin
                for (int b = 0; b < 4; b++) ref_mem[16'((addr & ~32'h3) + 32'(b))] = wd[8*b +: 8];
            end
            done_q.push_back(acc + 1);
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() + done_q.size() + op_q.size()) > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if ((exp_q.size() + done_q.size() + op_q.size()) > 0)
            flag("drain outstanding", 32'(exp_q.size() + done_q.size() + op_q.size()), 32'd0);
    endtask

    // ---------------- monitor ----------------
    int          n_en, kind_act;
    logic [31:0] addr_act, data_act;
    memop_t      mop;
    logic [67:0] e;
    int          dcyc;

    always @(negedge clk) begin
        if (!rst) begin
            n_en = int'(write_word_en) + int'(write_byte_en) + int'(read_word_en) + int'(read_byte_en);
            if (n_en > 1) flag("enable overlap", 32'(n_en), 32'd1);
            if (n_en >= 1) begin
                kind_act = write_word_en ? 0 : write_byte_en ? 1 : read_word_en ? 2 : 3;
                case (kind_act)
                    0:       begin addr_act = write_word_address; data_act = write_word_data; end
                    1:       begin addr_act = write_byte_address; data_act = {24'h0, write_byte_data}; end
                    2:       begin addr_act = read_word_address;  data_act = 32'd0; end
                    default: begin addr_act = read_byte_address;  data_act = 32'd0; end
                endcase
                if (op_q.size() == 0) begin
                    flag("unexpected enable", 32'(kind_act), 32'hFFFF_FFFF);
                end else begin
                    mop = op_q.pop_front();
                    chk("mem enable kind", 32'(kind_act), 32'(mop.kind));
                    chk("mem enable cycle", 32'(cyc), 32'(mop.cyc));
                    chk("mem address", addr_act, mop.addr);
                    if (mop.kind < 2) chk("mem write data", data_act, mop.data);
                end
            end else if (op_q.size() > 0 && op_q[0].cyc <= cyc) begin
                mop = op_q.pop_front();
                flag("missing enable", 32'd0, 32'(mop.kind));
            end

            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected wb_valid", wb_data, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_data", wb_data, e[31:0]);
                    chk("wb_rd", 32'(wb_rd), 32'(e[35:32]));
                    chk("wb latency", 32'(cyc), e[67:36]);
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][67:36]) <= cyc) begin
                e = exp_q.pop_front();
                flag("missing wb_valid", 32'd0, e[31:0]);
            end

            if (done) begin
                if (done_q.size() == 0) begin
                    flag("unexpected done", 32'd1, 32'd0);
                end else begin
                    dcyc = done_q.pop_front();
                    chk("done cycle", 32'(cyc), 32'(dcyc));
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                dcyc = done_q.pop_front();
                flag("missing done", 32'd0, 32'(dcyc));
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " mem enables"}, 32'({write_word_en, write_byte_en, read_word_en, read_byte_en}), 32'd0);
        chk({tag, " write_word_address"}, write_word_address, 32'd0);
        chk({tag, " write_byte_address"}, write_byte_address, 32'd0);
        chk({tag, " read_word_address"}, read_word_address, 32'd0);
        chk({tag, " read_byte_address"}, read_byte_address, 32'd0);
        chk({tag, " write data"}, write_word_data | 32'(write_byte_data), 32'd0);
        chk({tag, " wb_valid/done"}, 32'({wb_valid, done}), 32'd0);
        chk({tag, " wb_data"}, wb_data, 32'd0);
        chk({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int acc1, acc2, acc;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_rd    = 4'd0;

        #1;
        chk_outputs_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("req_ready after reset", 32'(req_ready), 32'd1);

        // Directed word/byte stores and loads, including unaligned rotation.
        issue(1'b0, 1'b0, 32'h1000, 32'hDEADBEEF, 4'd0, 1'b0, acc);
        issue(1'b1, 1'b0, 32'h1000, 32'd0, 4'd3, 1'b0, acc);
        issue(1'b1, 1'b0, 32'h1001, 32'd0, 4'd4, 1'b0, acc);
        issue(1'b1, 1'b0, 32'h1002, 32'd0, 4'd5, 1'b0, acc);
        issue(1'b1, 1'b0, 32'h1003, 32'd0, 4'd6, 1'b0, acc);
        issue(1'b0, 1'b1, 32'h1001, 32'hFFFFFFAA, 4'd0, 1'b0, acc);
        issue(1'b1, 1'b1, 32'h1001, 32'd0, 4'd7, 1'b0, acc);
        issue(1'b1, 1'b0, 32'h1000, 32'd0, 4'd8, 1'b0, acc);
        issue(1'b0, 1'b0, 32'h2003, 32'h12345678, 4'd0, 1'b0, acc);
        issue(1'b1, 1'b0, 32'h2000, 32'd0, 4'd9, 1'b0, acc);
        drain();

        // Back-to-back with req_valid held across the store.
        issue(1'b0, 1'b0, 32'h2100, 32'hCAFEF00D, 4'd0, 1'b1, acc1);
        issue(1'b1, 1'b0, 32'h2100, 32'd0, 4'd10, 1'b0, acc2);
        chk("back-to-back accept edge", 32'(acc2), 32'(acc1 + 2));
        drain();

        // Randomised traffic over a small window so loads hit earlier stores.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'h3000 + 32'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), acc);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        drain();

        // Reset during RD_ISSUE drops the load silently.
        issue(1'b1, 1'b0, 32'h1000, 32'd0, 4'd11, 1'b0, acc);
        #2;
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        op_q.delete();
        #1;
        chk_outputs_zero("mid-op reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready after mid-op reset", 32'(req_ready), 32'd1);
        chk("no wb_valid/done after reset", 32'({wb_valid, done}), 32'd0);
        issue(1'b1, 1'b0, 32'h1002, 32'd0, 4'd12, 1'b0, acc);
        issue(1'b1, 1'b1, 32'h2001, 32'd0, 4'd13, 1'b0, acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
